// File: rtl/riscv_pkg.sv
// Shared fetch-stage types: data width, default reset vector, buffer entry and FSM state.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    // Instruction fetches are always word aligned, so the two low bits are dropped.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with registered storage and a single-cycle flush.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array is written on push only; it needs no reset because empty gates its use.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; flush and reset both return the FIFO to empty.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// In-order fetch stage: owns the PC, issues credit-limited imem requests and buffers
// returned instructions for decode. Redirects flush the buffer and drain stale responses.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fd_valid,
    input  logic            fd_ready,
    output logic [XLEN-1:0] fd_instruction,
    output logic [XLEN-1:0] fd_pc
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_next;
    logic            req_fire;
    logic            credit_ok;
    logic            buf_push;
    logic            buf_pop;
    logic            tag_pop;
    fetch_entry_t    buf_in;
    fetch_entry_t    buf_out;
    logic            buf_full;
    logic            buf_empty;
    logic [CW-1:0]   buf_count;
    logic [XLEN-1:0] tag_head;
    logic            tag_full;
    logic            tag_empty;
    logic [CW-1:0]   tag_count;

    assign req_fire         = imem_req_valid && imem_req_ready;
    assign outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
    assign credit_ok        = ({1'b0, outstanding} + {1'b0, buf_count}) < (CW + 1)'(FIFO_DEPTH);
    assign imem_req_addr    = pc;

    assign buf_push = (state == RUN) && imem_rsp_valid && !redirect_valid;
    assign buf_pop  = fd_valid && fd_ready;
    assign tag_pop  = (state == RUN) && imem_rsp_valid && !tag_empty;
    assign buf_in   = '{pc: tag_head, instr: imem_rsp_data};

    assign fd_valid       = !buf_empty && !redirect_valid;
    assign fd_instruction = buf_empty ? '0 : buf_out.instr;
    assign fd_pc          = buf_empty ? '0 : buf_out.pc;

    // PC of every accepted request, popped in order as responses come back.
    fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_tag_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_fire),
        .pop   (tag_pop),
        .flush (redirect_valid),
        .din   (pc),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    // Instruction buffer feeding decode; registered, so a response is visible one cycle later.
    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_inst_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (buf_push),
        .pop   (buf_pop),
        .flush (redirect_valid),
        .din   (buf_in),
        .dout  (buf_out),
        .full  (buf_full),
        .empty (buf_empty),
        .count (buf_count)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a redirect with responses still in flight drains them before fetching again.
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (redirect_valid && (outstanding_next != '0)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (outstanding_next == '0) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // Request only in RUN with a free credit; held off during reset so nothing is accepted then.
    always_comb begin
        imem_req_valid = 1'b0;
        if (rst_n && (state == RUN) && credit_ok && !redirect_valid) begin
            imem_req_valid = 1'b1;
        end
    end

    // PC and in-flight counter; a redirect overrides any sequential advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            outstanding <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                pc <= align_word(redirect_pc);
            end else if (req_fire) begin
                pc <= pc + XLEN'(4);
            end
        end
    end

    // Credit invariants: in-flight never exceeds the buffer and the tag queue tracks requests.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (outstanding_next <= CW'(FIFO_DEPTH));
            assert (!(buf_push && buf_full));
            assert (!(req_fire && tag_full));
            assert ((state != RUN) || (tag_count == outstanding));
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by randomized traffic,
// checked against a stream model (decode sees consecutive word addresses from the last target).
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fd_valid;
    logic        fd_ready;
    logic [31:0] fd_instruction;
    logic [31:0] fd_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fd_valid       (fd_valid),
        .fd_ready       (fd_ready),
        .fd_instruction (fd_instruction),
        .fd_pc          (fd_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    mem_req_t    mem_q[$];
    int          cyc, tests, failed, inflight, deliveries, req_fires, last_due;
    int          rdy_pct, fdr_pct, redir_pct, lat;
    logic [31:0] exp_pc, exp_req;
    logic        s_req_fire, s_fd_fire, s_rsp, s_redirect, s_rst;
    logic [31:0] s_target, s_req_addr;
    logic        prev_stall;
    logic [31:0] prev_pc, prev_instr;

    // Memory contents: a scrambled function of the address so every word is distinct.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 2))
            0:       return $urandom();
            1:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            default: return 32'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge: memory responses plus random handshakes.
    task automatic applyStimulus();
        imem_req_ready = ($urandom_range(0, 99) < 32'(rdy_pct));
        fd_ready       = ($urandom_range(0, 99) < 32'(fdr_pct));
        redirect_valid = rst_n && ($urandom_range(0, 99) < 32'(redir_pct));
        redirect_pc    = pick_target();
        if (rst_n && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom();
        end
    endtask

    // Sample settled outputs mid-cycle and compare against the stream model.
    task automatic checkOutput();
        #1;
        s_rst      = rst_n;
        s_redirect = redirect_valid;
        s_target   = redirect_pc;
        s_rsp      = imem_rsp_valid;
        s_req_addr = imem_req_addr;
        s_req_fire = rst_n && imem_req_valid && imem_req_ready;
        s_fd_fire  = rst_n && fd_valid && fd_ready;
        if (rst_n) begin
            if (redirect_valid) begin
                compare("fd_valid_during_redirect", 32'(fd_valid), 0);
                compare("req_valid_during_redirect", 32'(imem_req_valid), 0);
            end
            if (imem_req_valid) compare("req_addr", imem_req_addr, exp_req);
            if (fd_valid) begin
                compare("fd_pc", fd_pc, exp_pc);
                compare("fd_instruction", fd_instruction, mem_word(exp_pc));
            end
            if (prev_stall && !redirect_valid) begin
                compare("stall_valid", 32'(fd_valid), 1);
                compare("stall_pc", fd_pc, prev_pc);
                compare("stall_instr", fd_instruction, prev_instr);
            end
            compare("inflight_bound", 32'(inflight <= DEPTH), 1);
        end
        prev_stall = rst_n && fd_valid && !fd_ready && !redirect_valid;
        prev_pc    = fd_pc;
        prev_instr = fd_instruction;
    endtask

    // Advance the model across the rising edge.
    task automatic finishCycle();
        int due;
        @(posedge clk);
        if (!s_rst) begin
            mem_q.delete();
            inflight = 0;
            exp_pc   = RPC;
            exp_req  = RPC;
        end else begin
            if (s_rsp) begin
                void'(mem_q.pop_front());
                inflight--;
            end
            if (s_req_fire) begin
                due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                mem_q.push_back('{s_req_addr, due});
                last_due = due;
                inflight++;
                req_fires++;
                exp_req += 32'd4;
            end
            if (s_fd_fire) begin
                exp_pc += 32'd4;
                deliveries++;
            end
            if (s_redirect) begin
                exp_pc  = {s_target[31:2], 2'b00};
                exp_req = {s_target[31:2], 2'b00};
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            applyStimulus();
            checkOutput();
            finishCycle();
        end
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        runCycles(2);
        rst_n = 1'b1;
    endtask

    // Called while rst_n is still low after at least one reset edge.
    task automatic checkResetState(input string tag);
        applyStimulus();
        checkOutput();
        compare({tag, "_fd_valid"}, 32'(fd_valid), 0);
        compare({tag, "_req_valid"}, 32'(imem_req_valid), 0);
        compare({tag, "_req_addr"}, imem_req_addr, RPC);
        compare({tag, "_fd_pc"}, fd_pc, 0);
        compare({tag, "_fd_instr"}, fd_instruction, 0);
        finishCycle();
    endtask

    task automatic redirectCycle(input logic [31:0] target);
        applyStimulus();
        redirect_valid = 1'b1;
        redirect_pc    = target;
        checkOutput();
        finishCycle();
    endtask

    task automatic waitReq(input string tag, input logic [31:0] addr, output int at);
        at = -1;
        for (int i = 0; i < 40 && at < 0; i++) begin
            applyStimulus();
            checkOutput();
            if (imem_req_valid) begin
                at = cyc;
                compare(tag, imem_req_addr, addr);
            end
            finishCycle();
        end
        compare({tag, "_seen"}, 32'(at >= 0), 1);
    endtask

    task automatic waitFd(input string tag, input logic [31:0] pcv);
        int at;
        at = -1;
        for (int i = 0; i < 40 && at < 0; i++) begin
            applyStimulus();
            checkOutput();
            if (fd_valid) begin
                at = cyc;
                compare(tag, fd_pc, pcv);
            end
            finishCycle();
        end
        compare({tag, "_seen"}, 32'(at >= 0), 1);
    endtask

    initial begin
        int start, first, f0, d0, at;
        logic done;
        tests = 0; failed = 0; cyc = 0; inflight = 0; deliveries = 0; req_fires = 0;
        last_due = 0; lat = 1; rdy_pct = 100; fdr_pct = 100; redir_pct = 0;
        exp_pc = RPC; exp_req = RPC; prev_stall = 1'b0; prev_pc = '0; prev_instr = '0;
        rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; fd_ready = 1'b0;
        @(negedge clk);

        // Scenario 1: reset state and first-instruction latency at full rate.
        runCycles(2);
        checkResetState("t1_reset");
        rst_n = 1'b1;
        start = cyc; first = -1; d0 = deliveries;
        for (int i = 0; i < 10; i++) begin
            applyStimulus();
            checkOutput();
            if (fd_valid && first < 0) first = cyc - start;
            finishCycle();
        end
        compare("t1_first_fd_valid_cycle", first, 2);
        runCycles(20);
        compare("t1_stream_progress", 32'(deliveries - d0 >= 8), 1);

        // Scenario 2: decode stalled; fetch stops after FIFO_DEPTH requests.
        resetDut();
        fdr_pct = 0;
        f0 = req_fires;
        runCycles(20);
        compare("t2_req_count", req_fires - f0, DEPTH);
        applyStimulus();
        checkOutput();
        compare("t2_held_valid", 32'(fd_valid), 1);
        compare("t2_held_pc", fd_pc, 32'h0);
        finishCycle();
        fdr_pct = 100;
        d0 = deliveries;
        runCycles(10);
        compare("t2_release_progress", 32'(deliveries - d0 >= 3), 1);

        // Scenario 3: redirect with two requests in flight at latency 4.
        lat = 4;
        resetDut();
        start = cyc;
        runCycles(2);
        compare("t3_inflight_before_redirect", inflight, 2);
        redirectCycle(32'h0000_0100);
        waitReq("t3_first_req_addr", 32'h0000_0100, at);
        compare("t3_first_req_cycle", at - start, 6);
        waitFd("t3_first_fd_pc", 32'h0000_0100);

        // Scenario 4: redirect coinciding with a decode handshake and a memory response.
        lat = 1;
        resetDut();
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            applyStimulus();
            #1;
            if (fd_valid && imem_rsp_valid) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'h0000_0340;
                done           = 1'b1;
            end
            checkOutput();
            finishCycle();
        end
        compare("t4_redirect_hit", 32'(done), 1);
        applyStimulus();
        checkOutput();
        compare("t4_empty_after_redirect", 32'(fd_valid), 0);
        finishCycle();
        waitFd("t4_first_fd_pc", 32'h0000_0340);

        // Scenario 5: unaligned target is masked; PC wraps at the top of the address space.
        lat = 2;
        resetDut();
        runCycles(5);
        redirectCycle(32'h0000_0203);
        waitReq("t5_masked_addr", 32'h0000_0200, at);
        runCycles(3);
        redirectCycle(32'hFFFF_FFFC);
        waitReq("t5_top_addr", 32'hFFFF_FFFC, at);
        waitReq("t5_wrap_addr", 32'h0000_0000, at);
        waitFd("t5_fd_top", 32'hFFFF_FFFC);

        // Scenario 6: reset while the buffer is full, then restart from the reset vector.
        lat = 1;
        resetDut();
        fdr_pct = 0;
        runCycles(10);
        compare("t6_full_valid", 32'(fd_valid), 1);
        rst_n = 1'b0;
        runCycles(1);
        checkResetState("t6_reset");
        rst_n = 1'b1;
        fdr_pct = 100;
        waitReq("t6_restart_addr", RPC, at);
        waitFd("t6_restart_pc", RPC);

        // Randomized traffic with occasional redirects and varying memory latency.
        resetDut();
        d0 = deliveries;
        for (int seg = 0; seg < 5; seg++) begin
            lat       = int'($urandom_range(1, 4));
            rdy_pct   = 70;
            fdr_pct   = 60;
            redir_pct = 4;
            runCycles(300);
        end
        compare("random_progress", 32'(deliveries - d0 > 100), 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
